ddr_out_lanes: RTL and testbench

//  Parametrised multi-lane DDR output serializer; successor to the single-bit DDIO wrapper.

---
 rtl/ddr_out_lanes.sv | 160 ++++++++++++++++
 tb/tb_ddr_out_lanes.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ddr_out_lanes.sv
// Multi-lane DDR output serializer: valid/ready word FIFO feeding per-lane ODDR-style pin drivers.
// Optional PRBS7 training mode is compiled in when DDR_OUT_PRBS_EN is defined.
module ddr_out_lanes #(
  parameter int         LANES       = 4,
  parameter int         DEPTH       = 8,
  parameter int         START_LEVEL = 4,
  parameter logic [1:0] IDLE_PAT    = 2'b00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [2*LANES-1:0]       s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun,
  input  logic                     underrun_clr,
`ifdef DDR_OUT_PRBS_EN
  input  logic                     train,
`endif
  output logic [LANES-1:0]         q
);

  localparam int                 AW        = $clog2(DEPTH);
  localparam int                 LW        = AW + 1;
  localparam logic [LW-1:0]      DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0]      START_L   = LW'(START_LEVEL);
  localparam logic [2*LANES-1:0] IDLE_WORD = {LANES{IDLE_PAT}};

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_TRAIN} state_t;

  state_t               r_state;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_s_ready;
  logic                 r_underrun;
  logic [2*LANES-1:0]   r_stage;
  logic [2*LANES-1:0]   r_oddr;
  logic [2*LANES-1:0]   r_mem [DEPTH];

  logic                 w_push;
  logic                 w_pop;
  logic [LW-1:0]        w_level_next;

  assign w_push = s_valid & r_s_ready;
  assign w_pop  = (r_state == S_RUN) && (r_level != '0);

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop)
      w_level_next = r_level + LW'(1);
    else if (!w_push && w_pop)
      w_level_next = r_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= s_data;
  end

`ifdef DDR_OUT_PRBS_EN
  logic [2*LANES-1:0] w_prbs_stage;

  // Each lane steps its PRBS7 twice per clk; the first new bit is the older one and lands in D0.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_prbs
    logic [6:0] r_prbs;
    logic [6:0] w_s1;
    logic       w_b0;
    logic       w_b1;

    assign w_b0 = r_prbs[6] ^ r_prbs[5];
    assign w_s1 = {r_prbs[5:0], w_b0};
    assign w_b1 = w_s1[6] ^ w_s1[5];
    assign w_prbs_stage[2*gi]   = w_b0;
    assign w_prbs_stage[2*gi+1] = w_b1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        r_prbs <= 7'(gi + 1);
      else if (r_state == S_TRAIN)
        r_prbs <= {w_s1[5:0], w_b1};
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_s_ready  <= 1'b0;
      r_underrun <= 1'b0;
      r_stage    <= IDLE_WORD;
    end else begin
      r_level   <= w_level_next;
      r_s_ready <= (w_level_next < DEPTH_L);
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
      if (underrun_clr)
        r_underrun <= 1'b0;
      r_stage <= IDLE_WORD;
      case (r_state)
        S_IDLE: begin
          if (en)
            r_state <= S_FILL;
        end
        S_FILL: begin
          if (!en)
            r_state <= S_IDLE;
          else if (r_level >= START_L)
            r_state <= S_RUN;
        end
        S_RUN: begin
          // An empty FIFO here is an underrun; it outranks a same-cycle clear.
          if (r_level != '0) begin
            r_stage <= r_mem[r_rd_ptr];
          end else begin
            r_underrun <= 1'b1;
            r_state    <= S_FILL;
          end
          if (!en)
            r_state <= S_IDLE;
        end
`ifdef DDR_OUT_PRBS_EN
        S_TRAIN: begin
          r_stage <= w_prbs_stage;
          if (!train)
            r_state <= S_FILL;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
`ifdef DDR_OUT_PRBS_EN
      if (train)
        r_state <= S_TRAIN;
`endif
    end
  end

  // Behavioural ODDR: capture the stage on the rising edge, drive D0 while clk is high, D1 while low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_oddr <= IDLE_WORD;
    else
      r_oddr <= r_stage;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_pin
    assign q[gi] = clk ? r_oddr[2*gi] : r_oddr[2*gi+1];
  end

  assign s_ready  = r_s_ready;
  assign level    = r_level;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_ddr_out_lanes.sv
// Directed bench for ddr_out_lanes: reset, full FIFO, simultaneous push/pop, prefill, underrun, reset mid-stream.
module tb_ddr_out_lanes;

  localparam int         LANES       = 4;
  localparam int         DEPTH       = 8;
  localparam int         START_LEVEL = 4;
  localparam logic [1:0] IDLE_PAT    = 2'b10;
  localparam logic [3:0] IDLE_HI     = 4'b0000;
  localparam logic [3:0] IDLE_LO     = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] level;
  logic       underrun;
  logic       underrun_clr;
  logic [3:0] q;
`ifdef DDR_OUT_PRBS_EN
  logic       train = 1'b0;
`endif

  int         checks = 0;
  int         errors = 0;
  logic [3:0] q_hi;
  logic [3:0] q_lo;
  logic [7:0] fw [9] = '{8'h01, 8'h80, 8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'hF0, 8'h0F, 8'h96};
  logic [7:0] pw [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [1:0] lane0_exp [4] = '{2'b10, 2'b00, 2'b11, 2'b00};

  always #5 clk = ~clk;

  ddr_out_lanes #(
    .LANES       (LANES),
    .DEPTH       (DEPTH),
    .START_LEVEL (START_LEVEL),
    .IDLE_PAT    (IDLE_PAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
`ifdef DDR_OUT_PRBS_EN
    .train        (train),
`endif
    .q            (q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; q is sampled in the high phase, then in the low phase.
  task automatic cyc;
    @(posedge clk);
    #1 q_hi = q;
    @(negedge clk);
    #1 q_lo = q;
  endtask

  function automatic logic [3:0] d0_of(input logic [7:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[2*i];
    return r;
  endfunction

  function automatic logic [3:0] d1_of(input logic [7:0] w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = w[2*i+1];
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; s_data = 8'h00; s_valid = 1'b0; underrun_clr = 1'b0;
    cyc; cyc;
    check("rst_level", 32'(level), 32'(0));
    check("rst_ready", 32'(s_ready), 32'(0));
    check("rst_underrun", 32'(underrun), 32'(0));
    check("rst_q_hi", 32'(q_hi), 32'(IDLE_HI));
    check("rst_q_lo", 32'(q_lo), 32'(IDLE_LO));

    rst = 1'b0;
    cyc;
    $display("step release: s_ready=%0b level=%0d", s_ready, level);
    check("ready_after_release", 32'(s_ready), 32'(1));

    // Fill all eight entries with the stream disabled, then offer a ninth word.
    for (int k = 0; k < 8; k++) begin
      s_data = fw[k]; s_valid = 1'b1;
      check($sformatf("ready_push%0d", k), 32'(s_ready), 32'(1));
      cyc;
      $display("push %0d: data=%02h level=%0d s_ready=%0b", k, fw[k], level, s_ready);
    end
    check("full_level", 32'(level), 32'(8));
    check("full_ready", 32'(s_ready), 32'(0));
    s_data = fw[8];
    cyc; cyc;
    $display("hold ninth: level=%0d s_ready=%0b", level, s_ready);
    check("held_level", 32'(level), 32'(8));
    check("held_ready", 32'(s_ready), 32'(0));
    check("idle_q_hi", 32'(q_hi), 32'(IDLE_HI));
    check("idle_q_lo", 32'(q_lo), 32'(IDLE_LO));

    // Enable: IDLE->FILL, FILL->RUN, first pop frees a slot, ninth word enters alongside the second pop.
    en = 1'b1;
    cyc; cyc; cyc;
    check("ready_after_pop", 32'(s_ready), 32'(1));
    check("level_after_pop", 32'(level), 32'(7));
    cyc;
    s_valid = 1'b0;
    check("simul_level", 32'(level), 32'(7));
    check("stream0_hi", 32'(q_hi), 32'(d0_of(fw[0])));
    check("stream0_lo", 32'(q_lo), 32'(d1_of(fw[0])));
    for (int k = 1; k < 9; k++) begin
      cyc;
      $display("stream %0d: q_hi=%h q_lo=%h level=%0d", k, q_hi, q_lo, level);
      check($sformatf("stream%0d_hi", k), 32'(q_hi), 32'(d0_of(fw[k])));
      check($sformatf("stream%0d_lo", k), 32'(q_lo), 32'(d1_of(fw[k])));
      if (k == 7) check("no_early_underrun", 32'(underrun), 32'(0));
    end
    check("underrun_set", 32'(underrun), 32'(1));
    cyc;
    check("after_underrun_q_hi", 32'(q_hi), 32'(IDLE_HI));
    check("after_underrun_q_lo", 32'(q_lo), 32'(IDLE_LO));
    check("after_underrun_level", 32'(level), 32'(0));
    underrun_clr = 1'b1;
    cyc;
    underrun_clr = 1'b0;
    check("underrun_cleared", 32'(underrun), 32'(0));

    // Prefill from FILL: nothing leaves until the fourth word is in.
    for (int k = 0; k < 4; k++) begin
      s_data = pw[k]; s_valid = 1'b1;
      cyc;
      check($sformatf("prefill_level%0d", k), 32'(level), 32'(k + 1));
      check($sformatf("prefill_q%0d", k), 32'(q_hi), 32'(IDLE_HI));
    end
    s_valid = 1'b0;
    cyc;
    check("fill_to_run_q", 32'(q_hi), 32'(IDLE_HI));
    cyc;
    check("first_pop_q", 32'(q_lo), 32'(IDLE_LO));
    for (int k = 0; k < 4; k++) begin
      cyc;
      $display("lane0 %0d: D0=%0b D1=%0b", k, q_hi[0], q_lo[0]);
      check($sformatf("lane0_pair%0d", k), 32'({q_hi[0], q_lo[0]}), 32'(lane0_exp[k]));
    end
    check("prefill_underrun", 32'(underrun), 32'(1));
    cyc;
    check("prefill_idle_hi", 32'(q_hi), 32'(IDLE_HI));
    check("prefill_idle_lo", 32'(q_lo), 32'(IDLE_LO));

    // Start another stream and hit reset in the middle of it.
    for (int k = 0; k < 4; k++) begin
      s_data = 8'h12 + 8'(k * 8'h22); s_valid = 1'b1;
      cyc;
    end
    s_valid = 1'b0;
    cyc; cyc; cyc;
    check("midstream_hi", 32'(q_hi), 32'(d0_of(8'h12)));
    check("midstream_lo", 32'(q_lo), 32'(d1_of(8'h12)));
    rst = 1'b1;
    #1;
    $display("reset mid-stream: q=%h level=%0d s_ready=%0b underrun=%0b", q, level, s_ready, underrun);
    check("mid_rst_q_lo", 32'(q), 32'(IDLE_LO));
    check("mid_rst_level", 32'(level), 32'(0));
    check("mid_rst_ready", 32'(s_ready), 32'(0));
    check("mid_rst_underrun", 32'(underrun), 32'(0));
    @(posedge clk);
    #1;
    check("mid_rst_q_hi", 32'(q), 32'(IDLE_HI));
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
